// File: rtl/systolic_result_store.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_result_store
//  Purpose  : Captures an NxN result tile from the systolic array and commits
//             it one row per cycle at a programmable base address. Each write
//             either overwrites the memory word or adds to it with signed
//             saturation. Readback goes through a registered port.
//  Revision : 1.0  initial release
// ============================================================================
module systolic_result_store #(
  parameter int N      = 4,
  parameter int IN_W   = 16,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     save_into_memory,
  input  logic [ADDR_W-1:0]        save_base_memory,
  input  logic                     acc_mode,
  input  logic [N*N*IN_W-1:0]      tile_flat,
  input  logic [ADDR_W-1:0]        addrO,
  output logic signed [IN_W-1:0]   dataO,
  output logic                     busy,
  output logic                     save_done,
  output logic                     ovf,
  output logic                     drop,
  input  logic                     clr_flags
);

  // The row counter needs at least one bit, even for a 1x1 tile.
  localparam int                    ROW_W    = (N > 1) ? $clog2(N) : 1;
  localparam logic [ROW_W-1:0]      LAST_ROW = ROW_W'(N - 1);
  localparam logic signed [IN_W-1:0] MAX_VAL = {1'b0, {(IN_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN_VAL = {1'b1, {(IN_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Snapshot of the accepted request; the live inputs are free to change.
  logic [N*N*IN_W-1:0]     snap;
  logic [ADDR_W-1:0]       base;
  logic                    mode;
  logic [ROW_W-1:0]        row;

  logic signed [IN_W-1:0]  mem [DEPTH];

  // Per-column datapath for the row currently being committed.
  logic [ADDR_W-1:0]       waddr [N];
  logic signed [IN_W-1:0]  elem  [N];
  logic signed [IN_W-1:0]  old   [N];
  logic signed [IN_W:0]    sum   [N];
  logic signed [IN_W-1:0]  wdata [N];
  logic [N-1:0]            wsat;

  logic accept;
  logic collide;
  logic any_sat;

  assign accept    = (state == ST_IDLE) && save_into_memory;
  assign collide   = (state != ST_IDLE) && save_into_memory;
  assign any_sat   = (state == ST_WRITE) && (|wsat);
  assign busy      = (state != ST_IDLE);
  assign save_done = (state == ST_DONE);

  // Compute address, saturated sum and final write data for each column.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      // Address arithmetic is done at ADDR_W bits so it wraps modulo DEPTH.
      waddr[j] = base + ADDR_W'(row) * ADDR_W'(N) + ADDR_W'(j);
      elem[j]  = snap[(int'(row) * N + j) * IN_W +: IN_W];
      old[j]   = mem[waddr[j]];
      sum[j]   = {old[j][IN_W-1], old[j]} + {elem[j][IN_W-1], elem[j]};
      // The sum overflowed IN_W when its two top bits disagree.
      wsat[j]  = mode && (sum[j][IN_W] != sum[j][IN_W-1]);
      if (!mode) begin
        wdata[j] = elem[j];
      end else if (wsat[j]) begin
        wdata[j] = sum[j][IN_W] ? MIN_VAL : MAX_VAL;
      end else begin
        wdata[j] = sum[j][IN_W-1:0];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: accept -> one edge per row -> single DONE cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (save_into_memory) state_nxt = ST_WRITE;
      ST_WRITE: if (row == LAST_ROW) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Latch the request on acceptance and step the row counter while writing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap <= '0;
      base <= '0;
      mode <= 1'b0;
      row  <= '0;
    end else if (accept) begin
      snap <= tile_flat;
      base <= save_base_memory;
      mode <= acc_mode;
      row  <= '0;
    end else if (state == ST_WRITE && row != LAST_ROW) begin
      row <= row + 1'b1;
    end
  end

  // Result memory: cleared by reset, one full row written per WRITE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else if (state == ST_WRITE) begin
      for (int j = 0; j < N; j++) begin
        mem[waddr[j]] <= wdata[j];
      end
    end
  end

  // Registered readback; a same-edge write is seen one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dataO <= '0;
    end else begin
      dataO <= mem[addrO];
    end
  end

  // Sticky status flags; a set on the clearing edge takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf  <= 1'b0;
      drop <= 1'b0;
    end else begin
      ovf  <= any_sat | (ovf  & ~clr_flags);
      drop <= collide | (drop & ~clr_flags);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_systolic_result_store.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_result_store
//  Purpose  : Self-checking bench for systolic_result_store with a memory
//             reference model kept as a plain integer array.
//  Revision : 1.0  initial release
// ============================================================================
module tb_systolic_result_store;

  localparam int N      = 4;
  localparam int IN_W   = 16;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int TW     = N * N * IN_W;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    save_into_memory = 1'b0;
  logic [ADDR_W-1:0]       save_base_memory = '0;
  logic                    acc_mode = 1'b0;
  logic [TW-1:0]           tile_flat = '0;
  logic [ADDR_W-1:0]       addrO = '0;
  logic signed [IN_W-1:0]  dataO;
  logic                    busy;
  logic                    save_done;
  logic                    ovf;
  logic                    drop;
  logic                    clr_flags = 1'b0;

  int errors = 0;
  int checks = 0;

  // Reference state.
  int ref_mem [DEPTH];
  bit ref_ovf;
  bit ref_drop;
  logic signed [IN_W-1:0] rd [DEPTH];

  systolic_result_store #(.N(N), .IN_W(IN_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .save_into_memory(save_into_memory),
    .save_base_memory(save_base_memory), .acc_mode(acc_mode),
    .tile_flat(tile_flat), .addrO(addrO), .dataO(dataO), .busy(busy),
    .save_done(save_done), .ovf(ovf), .drop(drop), .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) ref_mem[a] = 0;
    ref_ovf  = 0;
    ref_drop = 0;
  endtask

  // Apply a whole tile to the reference memory using the save rules.
  task automatic model_save(input logic [TW-1:0] t, input int b, input bit m);
    logic signed [IN_W-1:0] e;
    int a, s;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        e = t[(i*N+j)*IN_W +: IN_W];
        a = (b + i*N + j) % DEPTH;
        if (!m) begin
          ref_mem[a] = int'(e);
        end else begin
          s = ref_mem[a] + int'(e);
          if (s > 32767) begin s = 32767; ref_ovf = 1; end
          if (s < -32768) begin s = -32768; ref_ovf = 1; end
          ref_mem[a] = s;
        end
      end
    end
  endtask

  function automatic logic [TW-1:0] rand_tile();
    logic [TW-1:0] t;
    for (int k = 0; k < N*N; k++) t[k*IN_W +: IN_W] = IN_W'($urandom);
    return t;
  endfunction

  function automatic logic [TW-1:0] const_tile(input int v);
    logic [TW-1:0] t;
    for (int k = 0; k < N*N; k++) t[k*IN_W +: IN_W] = IN_W'(v);
    return t;
  endfunction

  // Pulse save for one edge, then scramble the live inputs.
  task automatic start_save(input logic [TW-1:0] t, input int b, input bit m);
    save_into_memory = 1'b1;
    tile_flat        = t;
    save_base_memory = ADDR_W'(b);
    acc_mode         = m;
    tick();
    save_into_memory = 1'b0;
    tile_flat        = rand_tile();
    save_base_memory = ADDR_W'($urandom);
    acc_mode         = 1'($urandom);
  endtask

  // Observe until busy drops, bounded to 20 cycles.
  task automatic wait_idle(output int busy_cyc, output int dones, output int done_idx);
    busy_cyc = 0; dones = 0; done_idx = -1;
    for (int c = 0; c < 20; c++) begin
      if (!busy) break;
      busy_cyc++;
      if (save_done) begin dones++; done_idx = c; end
      tick();
    end
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      addrO = ADDR_W'(a);
      tick();
      rd[a] = dataO;
    end
  endtask

  task automatic test_reset();
    int addrs [3] = '{0, 17, 255};
    rst = 1'b1;
    model_reset();
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      addrO = ADDR_W'(addrs[k]);
      tick();
      checks++;
      if (dataO !== 16'sd0) begin
        errors++;
        $display("FAIL reset_read[%0d]: got %0d expected 0", addrs[k], dataO);
      end
    end
    checks++;
    if ({busy, save_done, ovf, drop} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_status: got busy/done/ovf/drop=%b expected 0000",
               {busy, save_done, ovf, drop});
    end
  endtask

  task automatic test_overwrite();
    logic [TW-1:0] t;
    int bc, dn, di;
    for (int k = 0; k < N*N; k++) t[k*IN_W +: IN_W] = IN_W'(k + 1);
    model_save(t, 16, 0);
    start_save(t, 16, 0);
    wait_idle(bc, dn, di);
    checks++;
    if (bc !== 5) begin errors++; $display("FAIL ovw_busy_cycles: got %0d expected 5", bc); end
    checks++;
    if (dn !== 1 || di !== 4) begin
      errors++;
      $display("FAIL ovw_done_pulse: got count=%0d at=%0d expected count=1 at=4", dn, di);
    end
    read_all();
    for (int a = 15; a <= 32; a++) begin
      checks++;
      if (rd[a] !== 16'(ref_mem[a])) begin
        errors++;
        $display("FAIL ovw_read[%0d]: got %0d expected %0d", a, rd[a], ref_mem[a]);
      end
    end
  endtask

  task automatic test_accumulate();
    int bc, dn, di;
    start_save(const_tile(30000), 0, 0);  model_save(const_tile(30000), 0, 0);
    wait_idle(bc, dn, di);
    start_save(const_tile(5000), 0, 1);   model_save(const_tile(5000), 0, 1);
    wait_idle(bc, dn, di);
    checks++;
    if (ovf !== 1'b1 || ref_ovf !== 1'b1) begin
      errors++; $display("FAIL acc_ovf_set: got %b expected 1", ovf);
    end
    read_all();
    for (int a = 0; a < N*N; a++) begin
      checks++;
      if (rd[a] !== 16'(ref_mem[a]) || rd[a] !== 16'sd32767) begin
        errors++; $display("FAIL acc_sat[%0d]: got %0d expected 32767", a, rd[a]);
      end
    end
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    ref_ovf = 0; ref_drop = 0;
    checks++;
    if (ovf !== 1'b0) begin errors++; $display("FAIL acc_ovf_clear: got %b expected 0", ovf); end
    start_save(const_tile(-32768), 0, 1); model_save(const_tile(-32768), 0, 1);
    wait_idle(bc, dn, di);
    checks++;
    if (ovf !== ref_ovf) begin errors++; $display("FAIL acc_no_ovf: got %b expected %b", ovf, ref_ovf); end
    read_all();
    for (int a = 0; a < N*N; a++) begin
      checks++;
      if (rd[a] !== 16'(ref_mem[a]) || rd[a] !== -16'sd1) begin
        errors++; $display("FAIL acc_sum[%0d]: got %0d expected -1", a, rd[a]);
      end
    end
  endtask

  task automatic test_wrap();
    logic [TW-1:0] t;
    int bc, dn, di;
    for (int k = 0; k < N*N; k++) t[k*IN_W +: IN_W] = IN_W'(100 + k);
    model_save(t, 250, 0);
    start_save(t, 250, 0);
    wait_idle(bc, dn, di);
    read_all();
    checks++;
    if (rd[250] !== 16'sd100 || rd[0] !== 16'sd106 || rd[9] !== 16'sd115) begin
      errors++;
      $display("FAIL wrap_corners: got %0d/%0d/%0d expected 100/106/115", rd[250], rd[0], rd[9]);
    end
    for (int a = 0; a < DEPTH; a++) begin
      checks++;
      if (rd[a] !== 16'(ref_mem[a])) begin
        errors++; $display("FAIL wrap_mem[%0d]: got %0d expected %0d", a, rd[a], ref_mem[a]);
      end
    end
  endtask

  task automatic test_collision();
    logic [TW-1:0] ta, tb;
    int bc, dn, di;
    ta = rand_tile();
    tb = rand_tile();
    model_save(ta, 64, 0);
    ref_drop = 1;
    start_save(ta, 64, 0);
    tick();
    // Second request arrives mid-write and must be ignored.
    save_into_memory = 1'b1; tile_flat = tb; save_base_memory = 8'd64; acc_mode = 1'b0;
    tick();
    save_into_memory = 1'b0;
    wait_idle(bc, dn, di);
    checks++;
    if (drop !== ref_drop) begin errors++; $display("FAIL coll_drop: got %b expected 1", drop); end
    checks++;
    if (dn !== 1) begin errors++; $display("FAIL coll_done_count: got %0d expected 1", dn); end
    read_all();
    for (int a = 60; a < 84; a++) begin
      checks++;
      if (rd[a] !== 16'(ref_mem[a])) begin
        errors++; $display("FAIL coll_mem[%0d]: got %0d expected %0d", a, rd[a], ref_mem[a]);
      end
    end
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    ref_drop = 0; ref_ovf = 0;
  endtask

  task automatic test_read_before_write();
    logic [TW-1:0] tx, ty;
    logic signed [IN_W-1:0] oldv, newv;
    int bc, dn, di;
    tx = rand_tile();
    ty = rand_tile();
    ty[N*IN_W +: IN_W] = ~tx[N*IN_W +: IN_W];
    start_save(tx, 100, 0); model_save(tx, 100, 0);
    wait_idle(bc, dn, di);
    oldv = 16'(ref_mem[104]);
    model_save(ty, 100, 0);
    newv = 16'(ref_mem[104]);
    addrO = 8'd104;
    start_save(ty, 100, 0);
    tick();
    tick();
    checks++;
    if (dataO !== oldv) begin errors++; $display("FAIL rbw_old: got %0d expected %0d", dataO, oldv); end
    tick();
    checks++;
    if (dataO !== newv) begin errors++; $display("FAIL rbw_new: got %0d expected %0d", dataO, newv); end
    wait_idle(bc, dn, di);
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] t;
    int b, bc, dn, di;
    bit m;
    for (int n = 0; n < 8; n++) begin
      t = rand_tile();
      b = int'($urandom_range(0, DEPTH - 1));
      m = 1'($urandom);
      model_save(t, b, m);
      start_save(t, b, m);
      wait_idle(bc, dn, di);
      checks++;
      if (bc !== N + 1 || dn !== 1 || ovf !== ref_ovf || drop !== 1'b0) begin
        errors++;
        $display("FAIL b2b_status[%0d]: got busy=%0d done=%0d ovf=%b drop=%b expected %0d/1/%b/0",
                 n, bc, dn, ovf, drop, N + 1, ref_ovf);
      end
    end
    read_all();
    for (int a = 0; a < DEPTH; a++) begin
      checks++;
      if (rd[a] !== 16'(ref_mem[a])) begin
        errors++; $display("FAIL b2b_mem[%0d]: got %0d expected %0d", a, rd[a], ref_mem[a]);
      end
    end
  endtask

  task automatic test_reset_mid_save();
    int dn;
    start_save(rand_tile(), 8, 0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (busy !== 1'b0 || save_done !== 1'b0) begin
      errors++; $display("FAIL midrst_busy: got busy=%b done=%b expected 0/0", busy, save_done);
    end
    tick();
    rst = 1'b0;
    dn = 0;
    for (int c = 0; c < 8; c++) begin
      if (save_done) dn++;
      tick();
    end
    checks++;
    if (dn !== 0) begin errors++; $display("FAIL midrst_done: got %0d expected 0", dn); end
    read_all();
    for (int a = 0; a < DEPTH; a++) begin
      checks++;
      if (rd[a] !== 16'(ref_mem[a])) begin
        errors++; $display("FAIL midrst_mem[%0d]: got %0d expected 0", a, rd[a]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overwrite();
    test_accumulate();
    test_wrap();
    test_collision();
    test_read_before_write();
    test_back_to_back();
    test_reset_mid_save();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
